// File: rtl/min_sched_if.sv
// Request/operand/response bundle between the client engines, the shared min cell
// and the response consumer of min_sched.
interface min_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      op_a;
  logic [W-1:0]      op_b;
  logic [W-1:0]      op_res;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              busy;
  logic [15:0]       ops_done;

  modport slave (
    input  req_valid, req_a, req_b, op_res, rsp_ready,
    output req_ready, op_a, op_b, rsp_valid, rsp_id, rsp_data, busy, ops_done
  );

  modport master (
    output req_valid, req_a, req_b, op_res, rsp_ready,
    input  req_ready, op_a, op_b, rsp_valid, rsp_id, rsp_data, busy, ops_done
  );
endinterface

// File: rtl/min_sched.sv
// Round-robin arbiter time-sharing one registered 2-input min cell among NREQ requesters;
// one operation in flight, result returned tagged with the owning requester ID.
module min_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input logic        clk,
  input logic        rst,
  min_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [15:0]    ops_done_q, ops_done_d;

  logic           grant_vld;
  logic [IDW-1:0] grant_idx;

  // Search ptr+1, ptr+2, ... so the last granted requester has lowest priority next time.
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    idx       = 0;
    cand      = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx  = (int'(ptr_q) + k) % NREQ;
      cand = IDW'(idx);
      if (!grant_vld && bus.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      ops_done_q  <= ops_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    ops_done_d  = ops_done_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d  = ISSUE;
          ptr_d    = grant_idx;
          rsp_id_d = grant_idx;
          op_a_d   = bus.req_a[int'(grant_idx)*W +: W];
          op_b_d   = bus.req_b[int'(grant_idx)*W +: W];
        end
      end
      ISSUE: state_d = WAIT;
      // The cell sampled the operands at the end of ISSUE, so op_res is valid here.
      WAIT: begin
        state_d     = RESP;
        rsp_data_d  = bus.op_res;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && grant_vld && !rst) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
    bus.busy = (state_q != IDLE);
  end

  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.ops_done  = ops_done_q;

endmodule
